lo_sequencer: RTL

Controller that drives one `lo` mixer instance. It owns the free-running binary phase counter and converts it to Gray code. It selects the 7-bit Gray slice for a programmed core index, generates the matching `gray_sine` square wave, and sequences start and phase-aligned stop so the LO always begins and ends at phase zero. It sits between the channel configuration logic and the `lo` block's `gray_clk[7:1]` / `gray_sine` inputs.

---
 rtl/lo_pkg.sv | 17 +
 rtl/bin2gray.sv | 11 +
 rtl/lo_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lo_pkg.sv
// Shared types and constants for the LO phase sequencer.
package lo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lo_seq_state_t;

  localparam int SLICE_W = 7;

  // Highest core index whose 7-bit Gray slice still fits in the counter.
  function automatic int max_div(input int cnt_w);
    return cnt_w - SLICE_W;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Purely combinational binary-to-Gray converter.
module bin2gray #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/lo_sequencer.sv
// Phase counter, Gray slice select and phase-aligned start/stop control
// for a single lo mixer instance.
module lo_sequencer
  import lo_pkg::*;
#(
  parameter int CNT_W = 19,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             start,
  input  logic             stop,
  output logic [7:1]       gray_clk,
  output logic             gray_sine,
  output logic             wrap,
  output logic             running
);

  localparam int MAX_DIV = max_div(CNT_W);

  lo_seq_state_t      state_q, state_d;
  logic [CNT_W-1:0]   b_q, b_d;
  logic [DIV_W-1:0]   n_q, n_d;
  logic               hold_q, hold_d;
  logic [SLICE_W-1:0] gray_q, gray_d;
  logic               sine_q, sine_d;
  logic               wrap_q, wrap_d;

  logic [DIV_W-1:0]   div_sat;
  logic [CNT_W-1:0]   wrap_mask;
  logic [CNT_W-1:0]   g_next;
  logic               inc;
  logic               slice_wrap;

  assign div_sat   = (int'(cfg_div) > MAX_DIV) ? DIV_W'(MAX_DIV) : cfg_div;
  assign wrap_mask = {CNT_W{1'b1}} >> (MAX_DIV - int'(n_q));

  // The first RUN cycle holds B at zero so the LO starts with a full phase-0 step.
  assign inc        = (state_q != IDLE) && !hold_q;
  assign slice_wrap = inc && ((b_q & wrap_mask) == wrap_mask);

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    hold_d  = 1'b0;
    sine_d  = sine_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        b_d    = '0;
        sine_d = 1'b0;
        if (cfg_valid) n_d = div_sat;
        if (start) begin
          state_d = RUN;
          hold_d  = 1'b1;
        end
      end
      RUN: begin
        if (inc) b_d = b_q + CNT_W'(1);
        if (slice_wrap) begin
          wrap_d = 1'b1;
          sine_d = ~sine_q;
        end
        if (stop) begin
          if (slice_wrap) begin
            state_d = IDLE;
            b_d     = '0;
            sine_d  = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (inc) b_d = b_q + CNT_W'(1);
        if (slice_wrap) begin
          state_d = IDLE;
          b_d     = '0;
          sine_d  = 1'b0;
          wrap_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        b_d     = '0;
        sine_d  = 1'b0;
      end
    endcase
  end

  // Slice is taken from the next B so gray_clk and B update on the same edge.
  bin2gray #(.W(CNT_W)) u_bin2gray (
    .bin  (b_d),
    .gray (g_next)
  );

  assign gray_d = g_next[n_d +: SLICE_W];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      b_q     <= '0;
      n_q     <= '0;
      hold_q  <= 1'b0;
      gray_q  <= '0;
      sine_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      hold_q  <= hold_d;
      gray_q  <= gray_d;
      sine_q  <= sine_d;
      wrap_q  <= wrap_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign running   = (state_q != IDLE);
  assign gray_clk  = gray_q;
  assign gray_sine = sine_q;
  assign wrap      = wrap_q;

endmodule
